// File: rtl/ace_rd_arbiter.sv
// Two-requester ACE read arbiter: round-robin AR grant, single outstanding burst,
// zero-latency R routing to the owner, one-cycle RACK after the last beat.
module ace_rd_arbiter #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   s0_arid,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [7:0]        s0_arlen,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  input  logic [ID_W-1:0]   s1_arid,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [7:0]        s1_arlen,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [ID_W-1:0]   s0_rid,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [3:0]        s0_rresp,
  output logic              s0_rlast,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  output logic [ID_W-1:0]   s1_rid,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [3:0]        s1_rresp,
  output logic              s1_rlast,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [ID_W-1:0]   m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [ID_W-1:0]   m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [3:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              m_rack,
  output logic              grant,
  output logic              busy,
  output logic              beat_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ACK} state_t;

  state_t            state, state_nxt;
  logic              ptr;
  logic              win;
  logic              any_vld;
  logic              accept;
  logic              r_hs;
  logic [7:0]        beat_cnt;
  logic [ID_W-1:0]   cap_id;
  logic [ADDR_W-1:0] cap_addr;
  logic [7:0]        cap_len;

  // On a tie the requester that did not win last time goes first.
  assign any_vld = s0_arvalid | s1_arvalid;
  assign win     = (s0_arvalid & s1_arvalid) ? ~ptr : s1_arvalid;
  assign accept  = (state == IDLE) & any_vld;
  assign r_hs    = m_rvalid & m_rready;

  assign m_arid   = cap_id;
  assign m_araddr = cap_addr;
  assign m_arlen  = cap_len;
  assign s0_rid   = m_rid;
  assign s0_rdata = m_rdata;
  assign s0_rresp = m_rresp;
  assign s0_rlast = m_rlast;
  assign s1_rid   = m_rid;
  assign s1_rdata = m_rdata;
  assign s1_rresp = m_rresp;
  assign s1_rlast = m_rlast;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    m_rack     = 1'b0;
    case (state)
      IDLE: begin
        // Held off during reset so no requester sees a handshake that is then dropped.
        s0_arready = ~rst & s0_arvalid & ~win;
        s1_arready = ~rst & s1_arvalid & win;
        if (any_vld) state_nxt = ADDR;
      end
      ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_nxt = DATA;
      end
      DATA: begin
        m_rready  = grant ? s1_rready : s0_rready;
        s0_rvalid = m_rvalid & ~grant;
        s1_rvalid = m_rvalid & grant;
        if (r_hs && m_rlast) state_nxt = ACK;
      end
      ACK: begin
        m_rack    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 1'b1;
      grant    <= 1'b0;
      beat_cnt <= 8'd0;
      beat_err <= 1'b0;
      cap_id   <= '0;
      cap_addr <= '0;
      cap_len  <= 8'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cap_id   <= win ? s1_arid   : s0_arid;
        cap_addr <= win ? s1_araddr : s0_araddr;
        cap_len  <= win ? s1_arlen  : s0_arlen;
        grant    <= win;
        ptr      <= win;
        beat_cnt <= 8'd0;
      end
      if (r_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
        // Length mismatch is only flagged; the burst still runs to the downstream rlast.
        if (m_rlast ? (beat_cnt != cap_len) : (beat_cnt == cap_len)) beat_err <= 1'b1;
      end
    end
  end

endmodule
